// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
// Shared definitions for the 7-segment loopback capture block:
//   - FSM state encoding for seg_scan_capture
//   - active-low segment patterns (a..g, bit 6 = a) for digits 0..9
//   - blank/error codes and a one-hot-low anode helper
package seg_scan_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0 = 7'h01;
    localparam logic [6:0] SEG_1 = 7'h4F;
    localparam logic [6:0] SEG_2 = 7'h12;
    localparam logic [6:0] SEG_3 = 7'h06;
    localparam logic [6:0] SEG_4 = 7'h4C;
    localparam logic [6:0] SEG_5 = 7'h24;
    localparam logic [6:0] SEG_6 = 7'h20;
    localparam logic [6:0] SEG_7 = 7'h0F;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h04;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_ERR   = 4'hF;

    // True when exactly one bit of the active-low anode vector is low.
    function automatic logic is_onehot_low(input logic [7:0] an_v);
        logic [7:0] sel;
        sel = ~an_v;
        return (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd
// Combinational decode of an active-low 7-segment pattern back to a code.
//   pattern  in  7  segments a..g (bit 6 = a), active-low
//   code     out 4  0..9, CODE_BLANK for all-off, CODE_ERR otherwise
//   err      out 1  high when the pattern is not a recognised glyph
module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        code = CODE_ERR;
        err  = 1'b0;
        case (pattern)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                code = CODE_ERR;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
// Reads back the stopwatch's multiplexed 7-segment drive and rebuilds the
// displayed frame as eight 4-bit codes.
//   clk          in   system clock (same as display driver)
//   rst          in   asynchronous, active-high reset
//   an           in   8  anode strobes, active-low (an[i]=0 selects digit i)
//   dec_ddp      in   8  segments a..g on [7:1], dp on [0], all active-low
//   digits       out  32 captured frame, digits[4i+3:4i] = digit i
//   dp           out  8  captured decimal points, active-high
//   frame_valid  out  1  pulse when digits/dp are updated
//   pattern_err  out  1  pulse after sampling an undecodable pattern
//   anode_err    out  1  pulse when a settled anode value is not blank/one-hot
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_WAIT   | anodes blanked (8'hFF), nothing to sample
// S_SETTLE | anode value changed, waiting for SETTLE stable cycles
// S_HOLD   | current dwell already sampled (or rejected), wait for change
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an,
    input  logic [7:0]  dec_ddp,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic        frame_valid,
    output logic        pattern_err,
    output logic        anode_err
);

    localparam logic [7:0] STAB_TC = 8'(SETTLE - 1);

    logic [7:0] an_m, an_s;
    logic [7:0] seg_m, seg_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_m  <= 8'hFF;
            an_s  <= 8'hFF;
            seg_m <= 8'hFF;
            seg_s <= 8'hFF;
        end else begin
            an_m  <= an;
            an_s  <= an_m;
            seg_m <= dec_ddp;
            seg_s <= seg_m;
        end
    end

    // an_s is about to take a new value. Clearing stab on the same edge
    // that an_s changes makes stab count cycles since the change directly,
    // which gives the 2 + SETTLE pin-to-sample latency.
    logic an_chg;
    assign an_chg = (an_m != an_s);

    logic [7:0] stab;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab <= 8'd0;
        end else if (an_chg) begin
            stab <= 8'd0;
        end else if (stab != 8'hFF) begin
            stab <= stab + 8'd1;
        end
    end

    state_t state, state_d;
    logic   do_sample;
    logic   do_anerr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_WAIT;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        do_sample = 1'b0;
        do_anerr  = 1'b0;
        if (an_chg) begin
            state_d = (an_m == 8'hFF) ? S_WAIT : S_SETTLE;
        end else begin
            case (state)
                S_SETTLE: begin
                    if (stab == STAB_TC) begin
                        if (is_onehot_low(an_s)) begin
                            do_sample = 1'b1;
                            state_d   = S_HOLD;
                        end else if (an_s == 8'hFF) begin
                            state_d = S_WAIT;
                        end else begin
                            do_anerr = 1'b1;
                            state_d  = S_HOLD;
                        end
                    end
                end
                S_WAIT:  state_d = S_WAIT;
                S_HOLD:  state_d = S_HOLD;
                default: state_d = S_WAIT;
            endcase
        end
    end

    logic [2:0] idx;

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an_s[i]) idx = 3'(i);
        end
    end

    logic [3:0] dec_code;
    logic       dec_err;

    seg7_to_bcd u_dec (
        .pattern (seg_s[7:1]),
        .code    (dec_code),
        .err     (dec_err)
    );

    logic [7:0][3:0] work;
    logic [7:0]      work_dp;
    logic [7:0]      seen;
    logic [7:0]      seen_set;
    logic            frame_q;
    logic            perr_q;
    logic            aerr_q;

    assign seen_set = seen | (8'h01 << idx);

    // Sample stage: work/seen update on the sampling edge; the flags carry
    // the outcome one more cycle to the output registers below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work    <= '0;
            work_dp <= 8'h00;
            seen    <= 8'h00;
            frame_q <= 1'b0;
            perr_q  <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            perr_q  <= 1'b0;
            aerr_q  <= do_anerr;
            if (do_sample) begin
                work[idx]    <= dec_code;
                work_dp[idx] <= ~seg_s[0];
                perr_q       <= dec_err;
                if (seen_set == 8'hFF) begin
                    seen    <= 8'h00;
                    frame_q <= 1'b1;
                end else begin
                    seen <= seen_set;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= 32'h0;
            dp          <= 8'h00;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            frame_valid <= frame_q;
            pattern_err <= perr_q;
            anode_err   <= aerr_q;
            if (frame_q) begin
                digits <= work;
                dp     <= work_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

    localparam logic [6:0] P0 = 7'h01, P1 = 7'h4F, P2 = 7'h12, P3 = 7'h06,
                           P4 = 7'h4C, P5 = 7'h24, P6 = 7'h20, P7 = 7'h0F,
                           P8 = 7'h00, P9 = 7'h04, BLK = 7'h7F, BAD = 7'h55;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  an;
    logic [7:0]  dec_ddp;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic        frame_valid;
    logic        pattern_err;
    logic        anode_err;

    seg_scan_capture #(.SETTLE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .dec_ddp     (dec_ddp),
        .digits      (digits),
        .dp          (dp),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err),
        .anode_err   (anode_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int fv_cnt = 0, perr_cnt = 0, aerr_cnt = 0, both_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (frame_valid) fv_cnt++;
        if (pattern_err) perr_cnt++;
        if (anode_err) aerr_cnt++;
        if (frame_valid && pattern_err) both_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [6:0] pat, input logic dp_on);
        return {pat, ~dp_on};
    endfunction

    // Called at a negedge; drives one digit and holds it for dwell cycles.
    // first_fv = negedge index (1-based) of the first frame_valid seen.
    task automatic scan_digit(input int idx, input logic [7:0] seg, input int dwell,
                              output int first_fv);
        an       = ~(8'h01 << idx);
        dec_ddp  = seg;
        first_fv = 0;
        for (int k = 1; k <= dwell; k++) begin
            @(negedge clk);
            if (frame_valid && first_fv == 0) first_fv = k;
        end
    endtask

    task automatic blank(input int cycles);
        an      = 8'hFF;
        dec_ddp = 8'hFF;
        repeat (cycles) @(negedge clk);
    endtask

    typedef struct {
        string           name;
        logic [7:0][7:0] segs;
        logic [31:0]     exp_digits;
        logic [7:0]      exp_dp;
        int              exp_perr;
        int              exp_both;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int fv0, pe0, ae0, bo0, ffv;

        tbl[0].name = "plain";
        tbl[0].segs = {enc(P8,0), enc(P7,0), enc(P6,0), enc(P5,0),
                       enc(P4,0), enc(P3,0), enc(P2,0), enc(P1,0)};
        tbl[0].exp_digits = 32'h87654321; tbl[0].exp_dp = 8'h00;
        tbl[0].exp_perr = 0; tbl[0].exp_both = 0;

        tbl[1].name = "dp_blank";
        tbl[1].segs = {enc(P7,0), enc(P6,0), enc(BLK,0), enc(P4,0),
                       enc(P3,0), enc(P9,1), enc(P1,0), enc(P0,0)};
        tbl[1].exp_digits = 32'h76A43910; tbl[1].exp_dp = 8'h04;
        tbl[1].exp_perr = 0; tbl[1].exp_both = 0;

        tbl[2].name = "bad_mid";
        tbl[2].segs = {enc(P5,1), enc(P5,0), enc(P5,0), enc(P5,0),
                       enc(BAD,0), enc(P5,0), enc(P5,0), enc(P5,0)};
        tbl[2].exp_digits = 32'h5555F555; tbl[2].exp_dp = 8'h80;
        tbl[2].exp_perr = 1; tbl[2].exp_both = 0;

        tbl[3].name = "bad_last";
        tbl[3].segs = {enc(BAD,0), enc(P2,0), enc(P2,0), enc(P2,0),
                       enc(P2,0), enc(P2,0), enc(P2,0), enc(P2,0)};
        tbl[3].exp_digits = 32'hF2222222; tbl[3].exp_dp = 8'h00;
        tbl[3].exp_perr = 1; tbl[3].exp_both = 1;

        // Reset with anodes toggling through an invalid value
        rst = 1'b1; an = 8'h00; dec_ddp = 8'h00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            an = (k % 2 == 0) ? 8'hFF : 8'h00;
        end
        check("rst_digits", digits, 32'h0);
        check("rst_dp", {24'h0, dp}, 32'h0);
        check("rst_fv", {31'h0, frame_valid}, 32'h0);
        check("rst_perr", {31'h0, pattern_err}, 32'h0);
        check("rst_aerr", {31'h0, anode_err}, 32'h0);
        an = 8'hFF; dec_ddp = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        fv0 = fv_cnt; pe0 = perr_cnt; ae0 = aerr_cnt;
        repeat (30) @(negedge clk);
        check("idle_pulses", 32'(fv_cnt - fv0 + perr_cnt - pe0 + aerr_cnt - ae0), 32'h0);

        // Table-driven full frames
        for (int v = 0; v < 4; v++) begin
            fv0 = fv_cnt; pe0 = perr_cnt; ae0 = aerr_cnt; bo0 = both_cnt;
            for (int d = 0; d < 8; d++) begin
                scan_digit(d, tbl[v].segs[d], 40, ffv);
                if (d == 7) check({tbl[v].name, "_fv_latency"}, 32'(ffv), 32'd19);
            end
            blank(5);
            check({tbl[v].name, "_fv_count"}, 32'(fv_cnt - fv0), 32'd1);
            check({tbl[v].name, "_digits"}, digits, tbl[v].exp_digits);
            check({tbl[v].name, "_dp"}, {24'h0, dp}, {24'h0, tbl[v].exp_dp});
            check({tbl[v].name, "_perr"}, 32'(perr_cnt - pe0), 32'(tbl[v].exp_perr));
            check({tbl[v].name, "_both"}, 32'(both_cnt - bo0), 32'(tbl[v].exp_both));
            check({tbl[v].name, "_aerr"}, 32'(aerr_cnt - ae0), 32'd0);
        end

        // Reset mid-frame: partial frame must be discarded
        for (int d = 0; d < 5; d++) scan_digit(d, enc(P1, 0), 40, ffv);
        rst = 1'b1; an = 8'hFF; dec_ddp = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_digits", digits, 32'h0);
        fv0 = fv_cnt;
        scan_digit(5, enc(P6, 0), 40, ffv);
        scan_digit(6, enc(P7, 0), 40, ffv);
        scan_digit(7, enc(P8, 0), 40, ffv);
        check("midrst_no_early_fv", 32'(fv_cnt - fv0), 32'd0);
        scan_digit(0, enc(P1, 0), 40, ffv);
        scan_digit(1, enc(P2, 0), 40, ffv);
        scan_digit(2, enc(P3, 0), 40, ffv);
        scan_digit(3, enc(P4, 0), 40, ffv);
        scan_digit(4, enc(P5, 0), 40, ffv);
        blank(5);
        check("midrst_fv_count", 32'(fv_cnt - fv0), 32'd1);
        check("midrst_digits_full", digits, 32'h87654321);

        // Bad anode, then a too-short dwell on digit 0
        fv0 = fv_cnt; ae0 = aerr_cnt; pe0 = perr_cnt;
        an = 8'hFC; dec_ddp = enc(P3, 0);
        repeat (40) @(negedge clk);
        check("badan_aerr", 32'(aerr_cnt - ae0), 32'd1);
        scan_digit(0, enc(P9, 0), 10, ffv);
        for (int d = 1; d < 8; d++) scan_digit(d, enc(P1, 0), 40, ffv);
        check("badan_seen_kept", 32'(fv_cnt - fv0), 32'd0);
        scan_digit(0, enc(P0, 1), 40, ffv);
        blank(5);
        check("badan_fv_count", 32'(fv_cnt - fv0), 32'd1);
        check("badan_digits", digits, 32'h11111110);
        check("badan_dp", {24'h0, dp}, 32'h1);
        check("badan_aerr_total", 32'(aerr_cnt - ae0), 32'd1);
        check("badan_perr", 32'(perr_cnt - pe0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
